// File: rtl/countdown_sequencer_if.sv
// Mode-FSM enables in, BCD display / tick / zero-detect status out, for countdown_sequencer.
interface countdown_sequencer_if;
  logic       countdown_enable;
  logic       countuphr_enable;
  logic       countupmin_enable;
  logic       freeze;
  logic [7:0] disp_hr;
  logic [7:0] disp_min;
  logic [7:0] disp_sec;
  logic       sec_tick;
  logic       done;
  logic       alarm;

  modport master (
    output countdown_enable, countuphr_enable, countupmin_enable, freeze,
    input  disp_hr, disp_min, disp_sec, sec_tick, done, alarm
  );

  modport slave (
    input  countdown_enable, countuphr_enable, countupmin_enable, freeze,
    output disp_hr, disp_min, disp_sec, sec_tick, done, alarm
  );
endinterface

// File: rtl/countdown_sequencer.sv
// One-second prescaler, BCD HH:MM:SS time register, lap/display hold and zero-detect/alarm.
// Optional macro CDSEQ_RELOAD_EN adds a reload register restarting a finished countdown.
module countdown_sequencer #(
  parameter int CLK_DIV = 100000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  countdown_sequencer_if.slave  bus
);
  localparam int               CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                   return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    if (v == 8'h00)          return top;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [CNT_W-1:0] cnt_p0;
  logic             active, tc;
  logic [7:0]       hr, mn, sc, hr_n, mn_n, sc_n;
  logic             time_zero, done_n, alarm_n;
  logic             freeze_p1;
  logic [7:0]       disp_hr_r, disp_min_r, disp_sec_r;
  logic             sec_tick_r, done_r, alarm_r;
`ifdef CDSEQ_RELOAD_EN
  logic             cd_p1, cd_rise;
  logic [23:0]      reload;

  assign cd_rise = bus.countdown_enable && !cd_p1;
`endif

  assign active    = bus.countdown_enable || bus.countuphr_enable || bus.countupmin_enable;
  assign tc        = active && (cnt_p0 == CNT_LAST);
  assign time_zero = ({hr, mn, sc} == 24'd0);

  // Next-state of the time register; countdown outranks hour-set outranks minute-set
  always_comb begin
    hr_n    = hr;
    mn_n    = mn;
    sc_n    = sc;
    alarm_n = 1'b0;
`ifdef CDSEQ_RELOAD_EN
    if (cd_rise && time_zero && (reload != 24'd0)) begin
      {hr_n, mn_n, sc_n} = reload;
    end else
`endif
    if (tc) begin
      if (bus.countdown_enable) begin
        if (!time_zero) begin
          sc_n = bcd_dec(sc, 8'h59);
          if (sc == 8'h00)                  mn_n = bcd_dec(mn, 8'h59);
          if (sc == 8'h00 && mn == 8'h00)   hr_n = bcd_dec(hr, 8'h23);
          alarm_n = ({hr_n, mn_n, sc_n} == 24'd0);
        end
      end else if (bus.countuphr_enable) begin
        hr_n = bcd_inc(hr, 8'h23);
      end else begin
        mn_n = bcd_inc(mn, 8'h59);
      end
    end
    done_n = bus.countdown_enable && ({hr_n, mn_n, sc_n} == 24'd0);
  end

  // Stage p0: prescaler, time register and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p0     <= '0;
      sec_tick_r <= 1'b0;
      hr         <= 8'h00;
      mn         <= 8'h00;
      sc         <= 8'h00;
      done_r     <= 1'b0;
      alarm_r    <= 1'b0;
    end else begin
      if (!active || tc) cnt_p0 <= '0;
      else               cnt_p0 <= cnt_p0 + CNT_W'(1);
      sec_tick_r <= tc;
      hr         <= hr_n;
      mn         <= mn_n;
      sc         <= sc_n;
      done_r     <= done_n;
      alarm_r    <= alarm_n;
    end
  end

  // Stage p1: edge registers and display hold (rising freeze still loads the pre-update value)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freeze_p1  <= 1'b0;
      disp_hr_r  <= 8'h00;
      disp_min_r <= 8'h00;
      disp_sec_r <= 8'h00;
    end else begin
      freeze_p1 <= bus.freeze;
      if (!(bus.freeze && freeze_p1)) begin
        disp_hr_r  <= hr;
        disp_min_r <= mn;
        disp_sec_r <= sc;
      end
    end
  end

`ifdef CDSEQ_RELOAD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cd_p1  <= 1'b0;
      reload <= 24'd0;
    end else begin
      cd_p1 <= bus.countdown_enable;
      if (cd_rise && !time_zero) reload <= {hr, mn, sc};
    end
  end
`endif

  assign bus.disp_hr  = disp_hr_r;
  assign bus.disp_min = disp_min_r;
  assign bus.disp_sec = disp_sec_r;
  assign bus.sec_tick = sec_tick_r;
  assign bus.done     = done_r;
  assign bus.alarm    = alarm_r;
endmodule
